// File: rtl/expstate_mbox_pkg.sv
// Shared constants, helpers and types for the core0 -> core1 expstate mailbox.
package expstate_mbox_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int DEPTH_DEF   = 4;
  localparam int IRQ_GAP_DEF = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  typedef logic [WIDTH_DEF-1:0] mbox_word_t;

endpackage

// File: rtl/expstate_mailbox_fifo.sv
// Synchronous FIFO with a registered head word; storage itself is never reset.
module mbox_fifo
  import expstate_mbox_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_din,
  output logic [WIDTH-1:0]       o_head,
  output logic [clog2(DEPTH):0]  o_count,
  output logic [clog2(DEPTH):0]  o_next_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_pop_eff;
  logic             w_push_eff;
  logic [AW-1:0]    w_rd_next;
  logic [CW-1:0]    w_next_count;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  // A push into a full FIFO is only accepted when a pop frees the slot.
  assign w_pop_eff  = i_pop && !o_empty;
  assign w_push_eff = i_push && (!o_full || w_pop_eff);
  assign w_rd_next  = w_pop_eff ? r_rd + AW'(1) : r_rd;
  assign w_next_count = r_count + CW'(w_push_eff) - CW'(w_pop_eff);

  always_ff @(posedge i_clk) begin
    if (w_push_eff) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else begin
      if (w_pop_eff)  r_rd <= w_rd_next;
      if (w_push_eff) r_wr <= r_wr + AW'(1);
      r_count <= w_next_count;
      // Head holds its last value once the FIFO drains.
      if (w_next_count != '0)
        r_head <= (w_push_eff && (r_wr == w_rd_next)) ? i_din : r_mem[w_rd_next];
    end
  end

  assign o_head       = r_head;
  assign o_count      = r_count;
  assign o_next_count = w_next_count;

endmodule

// File: rtl/expstate_mailbox.sv
// Captures every change of core0's TIE_EXPSTATE into a FIFO and raises
// BInterrupt06 to core1 while entries are pending, with a post-drain low gap.
module expstate_mailbox
  import expstate_mbox_pkg::*;
#(
  parameter int               WIDTH     = WIDTH_DEF,
  parameter int               DEPTH     = DEPTH_DEF,
  parameter int               IRQ_GAP   = IRQ_GAP_DEF,
  parameter logic [WIDTH-1:0] PREV_INIT = '0
) (
  input  logic                  CLK,
  input  logic                  BReset,
  input  logic [WIDTH-1:0]      TIE_EXPSTATE,
  input  logic                  MboxPop,
  input  logic                  MboxOvfClr,
  output logic [WIDTH-1:0]      MboxData,
  output logic [clog2(DEPTH):0] MboxCount,
  output logic                  MboxOverflow,
  output logic                  BInterrupt06
);

  localparam int CW = clog2(DEPTH) + 1;
  localparam int GW = clog2(IRQ_GAP + 2);

  logic [WIDTH-1:0] r_prev;
  logic             r_ovf;
  logic [GW-1:0]    r_gap;
  logic             r_irq;

  logic             w_push;
  logic             w_pop_eff;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_next_count;
  logic [GW-1:0]    w_next_gap;
  logic             w_ovf_set;

  assign w_push    = (TIE_EXPSTATE != r_prev);
  assign w_pop_eff = MboxPop && !w_empty;
  assign w_ovf_set = w_push && w_full && !w_pop_eff;

  mbox_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk        (CLK),
    .i_rst        (BReset),
    .i_push       (w_push),
    .i_pop        (MboxPop),
    .i_din        (TIE_EXPSTATE),
    .o_head       (MboxData),
    .o_count      (MboxCount),
    .o_next_count (w_next_count),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  // The gap only restarts when the last entry leaves and nothing replaces it.
  always_comb begin
    w_next_gap = r_gap;
    if (w_pop_eff && (MboxCount == CW'(1)) && !w_push)
      w_next_gap = GW'(IRQ_GAP);
    else if (r_gap != '0)
      w_next_gap = r_gap - GW'(1);
  end

  always_ff @(posedge CLK or posedge BReset) begin
    if (BReset) begin
      r_prev <= PREV_INIT;
      r_ovf  <= 1'b0;
      r_gap  <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_prev <= TIE_EXPSTATE;
      if (w_ovf_set)       r_ovf <= 1'b1;
      else if (MboxOvfClr) r_ovf <= 1'b0;
      r_gap <= w_next_gap;
      r_irq <= (w_next_count != '0) && (w_next_gap == '0);
    end
  end

  assign MboxOverflow = r_ovf;
  assign BInterrupt06 = r_irq;

endmodule

// File: tb/tb_expstate_mailbox.sv
// Randomised and directed bench for expstate_mailbox with a queue-based reference model.
module tb_expstate_mailbox;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int IRQ_GAP = 2;

  logic              CLK;
  logic              BReset;
  logic [WIDTH-1:0]  TIE_EXPSTATE;
  logic              MboxPop;
  logic              MboxOvfClr;
  logic [WIDTH-1:0]  MboxData;
  logic [2:0]        MboxCount;
  logic              MboxOverflow;
  logic              BInterrupt06;

  expstate_mailbox #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .IRQ_GAP   (IRQ_GAP),
    .PREV_INIT ('0)
  ) dut (
    .CLK          (CLK),
    .BReset       (BReset),
    .TIE_EXPSTATE (TIE_EXPSTATE),
    .MboxPop      (MboxPop),
    .MboxOvfClr   (MboxOvfClr),
    .MboxData     (MboxData),
    .MboxCount    (MboxCount),
    .MboxOverflow (MboxOverflow),
    .BInterrupt06 (BInterrupt06)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]       cnt;
    logic [WIDTH-1:0] data;
    logic             ovf;
    logic             irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: a bounded queue of words, a sticky flag and a countdown.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_prev;
  logic [WIDTH-1:0] m_data;
  logic             m_ovf;
  int               m_gap;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, expv);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_prev = '0;
    m_data = '0;
    m_ovf  = 1'b0;
    m_gap  = 0;
  endtask

  function automatic exp_t model_step(input logic [WIDTH-1:0] tie, input logic pop, input logic clr);
    exp_t e;
    bit   changed, popped, last_one, dropped;
    changed  = (tie != m_prev);
    m_prev   = tie;
    popped   = pop && (m_q.size() > 0);
    last_one = (m_q.size() == 1);
    dropped  = 1'b0;
    if (popped) void'(m_q.pop_front());
    if (changed) begin
      if (m_q.size() < DEPTH) m_q.push_back(tie);
      else dropped = 1'b1;
    end
    if (dropped)  m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (popped && last_one && !changed) m_gap = IRQ_GAP;
    else if (m_gap > 0)                 m_gap = m_gap - 1;
    if (m_q.size() > 0) m_data = m_q[0];
    e.cnt  = 3'(m_q.size());
    e.data = m_data;
    e.ovf  = m_ovf;
    e.irq  = (m_q.size() > 0) && (m_gap == 0);
    return e;
  endfunction

  task automatic step(input logic [WIDTH-1:0] tie, input logic pop, input logic clr);
    exp_t e;
    TIE_EXPSTATE = tie;
    MboxPop      = pop;
    MboxOvfClr   = clr;
    e = model_step(tie, pop, clr);
    @(posedge CLK);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_count"}, WIDTH'(MboxCount), '0);
    chk({tag, "_data"},  MboxData, '0);
    chk({tag, "_ovf"},   WIDTH'(MboxOverflow), '0);
    chk({tag, "_irq"},   WIDTH'(BInterrupt06), '0);
  endtask

  // Monitor: compares the DUT against whatever the driver predicted for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count", WIDTH'(MboxCount), WIDTH'(e.cnt));
        chk("data",  MboxData, e.data);
        chk("ovf",   WIDTH'(MboxOverflow), WIDTH'(e.ovf));
        chk("irq",   WIDTH'(BInterrupt06), WIDTH'(e.irq));
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] v;
    int pop_pct;
    BReset       = 1'b1;
    TIE_EXPSTATE = '0;
    MboxPop      = 1'b0;
    MboxOvfClr   = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1 check_all_zero("in_reset");
    @(negedge CLK);
    #1 BReset = 1'b0;

    // Quiet input, then a single change.
    repeat (10) step('0, 1'b0, 1'b0);
    step(32'h1, 1'b0, 1'b0);
    step(32'h1, 1'b0, 1'b0);
    step(32'h1, 1'b1, 1'b0);
    repeat (3) step(32'h1, 1'b0, 1'b0);

    // Five changes into a 4-deep FIFO, then drain and clear.
    step(32'h11, 1'b0, 1'b0);
    step(32'h22, 1'b0, 1'b0);
    step(32'h33, 1'b0, 1'b0);
    step(32'h44, 1'b0, 1'b0);
    step(32'h55, 1'b0, 1'b0);
    step(32'h55, 1'b0, 1'b0);
    repeat (4) step(32'h55, 1'b1, 1'b0);
    step(32'h55, 1'b1, 1'b0);
    repeat (3) step(32'h55, 1'b0, 1'b0);
    step(32'h55, 1'b0, 1'b1);

    // Interrupt gap after draining, with a change arriving inside the gap.
    step(32'h66, 1'b0, 1'b0);
    step(32'h66, 1'b1, 1'b0);
    step(32'h77, 1'b0, 1'b0);
    repeat (3) step(32'h77, 1'b0, 1'b0);
    step(32'h77, 1'b1, 1'b0);
    repeat (3) step(32'h77, 1'b0, 1'b0);

    // Full FIFO with a simultaneous change and pop.
    step(32'h81, 1'b0, 1'b0);
    step(32'h82, 1'b0, 1'b0);
    step(32'h83, 1'b0, 1'b0);
    step(32'h84, 1'b0, 1'b0);
    step(32'hAA, 1'b1, 1'b0);
    repeat (4) step(32'hAA, 1'b1, 1'b0);
    repeat (3) step(32'hAA, 1'b0, 1'b0);

    // Overflow set and clear in the same cycle, then clear alone.
    step(32'h91, 1'b0, 1'b0);
    step(32'h92, 1'b0, 1'b0);
    step(32'h93, 1'b0, 1'b0);
    step(32'h94, 1'b0, 1'b0);
    step(32'h95, 1'b0, 1'b1);
    step(32'h95, 1'b0, 1'b1);
    repeat (4) step(32'h95, 1'b1, 1'b0);
    step(32'h95, 1'b1, 1'b0);
    repeat (3) step(32'h95, 1'b0, 1'b0);

    // Asynchronous reset mid-stream with three entries queued.
    step(32'hA1, 1'b0, 1'b0);
    step(32'hA2, 1'b0, 1'b0);
    step(32'hA3, 1'b0, 1'b0);
    @(negedge CLK);
    #1 BReset = 1'b1;
    #1 check_all_zero("async_reset");
    TIE_EXPSTATE = 32'h5;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1 BReset = 1'b0;
    model_reset();
    repeat (3) step(32'h5, 1'b0, 1'b0);
    step(32'h5, 1'b1, 1'b0);
    repeat (3) step(32'h5, 1'b0, 1'b0);

    // Random traffic in segments with varying drain pressure.
    for (int seg = 0; seg < 15; seg++) begin
      pop_pct = (seg % 3 == 0) ? 15 : ((seg % 3 == 1) ? 50 : 85);
      for (int i = 0; i < 200; i++) begin
        v = TIE_EXPSTATE;
        if ($urandom_range(99) < 50) v = WIDTH'($urandom_range(7)) << ($urandom_range(3) * 8);
        step(v, $urandom_range(99) < pop_pct, $urandom_range(99) < 8);
      end
    end

    repeat (3) @(negedge CLK);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/expstate_mailbox.md
Name: expstate_mailbox

Overview:
- Bridges core0's exported TIE state to core1's interrupt input.
- Each change of TIE_EXPSTATE is captured into a small FIFO.
- BInterrupt06 to core1 is held high while captured values are pending; core1 drains them through a pop strobe.
- Sits between core0's TIE_EXPSTATE output and core1's BInterrupt06 input in the two-core cosim system.

Parameters:
- WIDTH, 32, bit width of TIE_EXPSTATE and of each FIFO entry.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- IRQ_GAP, 2, minimum number of low cycles on BInterrupt06 after the FIFO drains to empty; 0 disables the gap.
- PREV_INIT, 0, reset value of the change-detect register.

Ports:
- CLK  in  1  single clock; all logic on the rising edge.
- BReset  in  1  reset, asynchronous assert, active-high.
- TIE_EXPSTATE  in  WIDTH  export state from core0.
- MboxPop  in  1  core1 consumes the head entry.
- MboxOvfClr  in  1  clears MboxOverflow.
- MboxData  out  WIDTH  head entry; valid when MboxCount != 0.
- MboxCount  out  clog2(DEPTH)+1  number of occupied entries.
- MboxOverflow  out  1  sticky; set when a change is dropped.
- BInterrupt06  out  1  level interrupt to core1.

Behaviour:
- Reset values:
  - MboxCount=0, MboxData=0, MboxOverflow=0, BInterrupt06=0.
  - Change-detect register prev=PREV_INIT; gap counter=0; read and write pointers=0.
- Change detect:
  - prev <= TIE_EXPSTATE every cycle.
  - push = (TIE_EXPSTATE != prev), evaluated combinationally in cycle t.
  - A value held constant produces exactly one push.
  - The first cycle after reset pushes if TIE_EXPSTATE != PREV_INIT.
- Push latency: a change in cycle t is written at the end of t; MboxCount and MboxData reflect it in cycle t+1.
- Pop: valid only when MboxCount != 0; the head advances at the end of the cycle. Pop when empty is ignored with no state change.
- Push and pop in the same cycle:
  - Count is unchanged; both take effect.
  - Legal when full (no overflow).
  - Legal when empty: the push is stored and the pop is ignored, so count becomes 1.
- Overflow:
  - Push when full without pop: the new value is dropped, FIFO contents are unchanged, and MboxOverflow is set in t+1.
  - MboxOvfClr clears it; if set and clear happen in the same cycle, set wins.
- Pointers: wrap modulo DEPTH. MboxCount is a separate counter with range 0..DEPTH.
- MboxData: registered copy of the head entry; updated with the count.
- Interrupt, registered:
  - BInterrupt06(t+1) = (next_count != 0) && (next_gap == 0).
  - Asserts in the same cycle MboxCount first becomes nonzero.
- Gap counter:
  - Loaded with IRQ_GAP when a pop takes count from 1 to 0 with no simultaneous push.
  - Otherwise decrements while nonzero.
  - While the counter is nonzero, BInterrupt06 stays low even if new entries arrive; it rises in the first cycle the counter is 0 and count != 0.
- Reset mid-operation: all state clears immediately on BReset assertion; FIFO contents are discarded and need not be cleared in storage.
- No X propagation: MboxData holds its last value when empty.

Decomposition:
- Package expstate_mbox_pkg:
  - Constants DEPTH_DEF, IRQ_GAP_DEF.
  - Function clog2.
  - Typedef mbox_word_t (logic [WIDTH-1:0]) for default WIDTH.
- Sub-module mbox_fifo: synchronous FIFO with push/pop/count/full/empty and registered head.
- Top level holds change detect, overflow flag, gap counter and interrupt register.

Test Plan:
- Reset, TIE_EXPSTATE=0 held -> no push, BInterrupt06=0, MboxCount=0 for 10 cycles; then drive 0x00000001 at t -> MboxCount=1, MboxData=0x00000001, BInterrupt06=1 at t+1.
- Drive 0x11,0x22,0x33,0x44,0x55 on consecutive cycles, no pops -> MboxCount=4, MboxOverflow=1 at the cycle after 0x55; pops return 0x11,0x22,0x33,0x44.
- Pop when MboxCount=1 with IRQ_GAP=2 -> BInterrupt06=0 next cycle; new change arriving during the gap gives MboxCount=1 but BInterrupt06 low for 2 cycles, then high.
- Full FIFO, simultaneous change 0xAA and MboxPop -> MboxCount stays 4, MboxOverflow stays 0, 0xAA returned as the 4th pop.
- MboxOvfClr asserted in the same cycle as a new overflow -> MboxOverflow remains 1; clear alone the next cycle -> 0.
- BReset asserted asynchronously mid-stream with MboxCount=3 -> all outputs 0 before the next CLK edge; TIE_EXPSTATE=0x5 on release -> single push of 0x5.
